// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side handshake plus RAM-side bus shared by the arbiter and its clients.
interface ram_arbiter_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
);
  logic              req0, req1;
  logic              we0, we1;
  logic [AWIDTH-1:0] addr0, addr1;
  logic [DWIDTH-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DWIDTH-1:0] rdata;
  logic              ram_load;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_d;
  logic [DWIDTH-1:0] ram_q;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_load, ram_addr, ram_d
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_load, ram_addr, ram_d
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port RAM between CPU (port 0) and loader (port 1),
// with a bounded burst per owner under contention and 1-cycle tagged read responses.
module ram_arbiter #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 12,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);
  typedef enum logic [1:0] {NONE, P0, P1} owner_t;
  owner_t          owner_q, owner_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic            last_q, last_d;
  logic            rvalid0_q, rvalid1_q;
  logic            any, sel1, keep0, keep1;
  always_comb begin
    keep0    = owner_q == P0 && burst_q < MAX_B;
    keep1    = owner_q == P1 && burst_q < MAX_B;
    any      = rst_n & (bus.req0 | bus.req1);
    // Under contention the current owner keeps the RAM until its burst is spent, then the other port gets it.
    sel1     = bus.req1 & (~bus.req0 | keep1 | (~keep0 & ~last_q));
    owner_d  = any ? (sel1 ? P1 : P0) : NONE;
    last_d   = any ? sel1 : last_q;
    burst_d  = !any ? '0 :
               owner_q != owner_d ? CW'(1) :
               burst_q == MAX_B ? burst_q : burst_q + 1'b1;
  end
  assign bus.gnt0     = any & ~sel1;
  assign bus.gnt1     = any & sel1;
  assign bus.ram_load = any & (sel1 ? bus.we1 : bus.we0);
  assign bus.ram_addr = any ? (sel1 ? bus.addr1 : bus.addr0) : '0;
  assign bus.ram_d    = any ? (sel1 ? bus.wdata1 : bus.wdata0) : '0;
  assign bus.rdata    = bus.ram_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= NONE;
      burst_q   <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      rvalid0_q <= bus.gnt0 & ~bus.we0;
      rvalid1_q <= bus.gnt1 & ~bus.we1;
    end
  end
endmodule
